// File: rtl/adc_serial_capture.sv
// Six-channel serial ADC front end: drives a shared adc_clk/cs_n pair, deserialises all six
// data lines together and presents one coherent sample with a valid strobe and running index.
module adc_serial_capture #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned LEAD_BITS  = 1,
  parameter int unsigned NUM_BITS   = 8,
  parameter int unsigned GAP_CYCLES = 50,
  parameter int unsigned IDX_W      = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [5:0]          data_in,
  output logic                adc_clk,
  output logic                cs_n,
  output logic [NUM_BITS-1:0] phase_a_v,
  output logic [NUM_BITS-1:0] phase_b_v,
  output logic [NUM_BITS-1:0] phase_c_v,
  output logic [NUM_BITS-1:0] phase_a_i,
  output logic [NUM_BITS-1:0] phase_b_i,
  output logic [NUM_BITS-1:0] phase_c_i,
  output logic                data_valid,
  output logic [IDX_W-1:0]    sample_index,
  output logic                busy
);

  localparam int unsigned NumEdges = 2 * (LEAD_BITS + NUM_BITS);
  localparam int unsigned DivW     = $clog2(CLK_DIV);
  localparam int unsigned EdgeW    = $clog2(NumEdges);
  localparam int unsigned GapW     = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StConv, StGap} state_e;

  state_e                    state_q, state_d;
  logic [DivW-1:0]           div_q, div_d;
  logic [EdgeW-1:0]          edge_q, edge_d;
  logic [GapW-1:0]           gap_q, gap_d;
  logic                      adc_clk_q, adc_clk_d;
  logic                      cs_n_q, cs_n_d;
  logic                      valid_q, valid_d;
  logic [5:0][NUM_BITS-1:0]  shift_q, shift_d;
  logic [5:0][NUM_BITS-1:0]  word_q, word_d;
  logic [IDX_W-1:0]          count_q, count_d;
  logic [IDX_W-1:0]          index_q, index_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      edge_q    <= '0;
      gap_q     <= '0;
      adc_clk_q <= 1'b0;
      cs_n_q    <= 1'b1;
      valid_q   <= 1'b0;
      shift_q   <= '0;
      word_q    <= '0;
      count_q   <= '0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      gap_q     <= gap_d;
      adc_clk_q <= adc_clk_d;
      cs_n_q    <= cs_n_d;
      valid_q   <= valid_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      count_q   <= count_d;
      index_q   <= index_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    gap_d     = gap_q;
    adc_clk_d = adc_clk_q;
    cs_n_d    = cs_n_q;
    valid_d   = 1'b0;
    shift_d   = shift_q;
    word_d    = word_q;
    count_d   = count_q;
    index_d   = index_q;

    unique case (state_q)
      StIdle: begin
        adc_clk_d = 1'b0;
        cs_n_d    = 1'b1;
        if (enable) begin
          state_d = StConv;
          cs_n_d  = 1'b0;
          div_d   = '0;
          edge_d  = '0;
          shift_d = '0;
        end
      end
      StConv: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d     = '0;
          edge_d    = edge_q + 1'b1;
          adc_clk_d = ~adc_clk_q;
          // Lead bits are simply shifted out the top by the later data bits.
          if (!adc_clk_q) begin
            for (int ch = 0; ch < 6; ch++) begin
              shift_d[ch] = (shift_q[ch] << 1) | NUM_BITS'(data_in[ch]);
            end
          end
          if (edge_q == EdgeW'(NumEdges - 1)) begin
            state_d = StGap;
            cs_n_d  = 1'b1;
            valid_d = 1'b1;
            word_d  = shift_q;
            index_d = count_q;
            count_d = count_q + 1'b1;
            gap_d   = '0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        // Passing through idle for one cycle gives the GAP_CYCLES+1 high time.
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign adc_clk      = adc_clk_q;
  assign cs_n         = cs_n_q;
  assign busy         = ~cs_n_q;
  assign data_valid   = valid_q;
  assign sample_index = index_q;
  assign phase_a_v    = word_q[0];
  assign phase_b_v    = word_q[1];
  assign phase_c_v    = word_q[2];
  assign phase_a_i    = word_q[3];
  assign phase_b_i    = word_q[4];
  assign phase_c_i    = word_q[5];

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
Drives six serial 8-bit ADCs (three phase voltages, three phase currents) that share one clock/chip-select pair. Deserialises all six data lines in parallel. Presents one coherent 6-channel sample with a single-cycle valid strobe and a running sample index. Sits directly upstream of the data-store stage, which writes each valid sample into on-chip RAM at the supplied index.

Parameters:
CLK_DIV, 25, clk cycles per adc_clk half-period (min 2); 25 gives 1 MHz adc_clk from 50 MHz clk
LEAD_BITS, 1, adc_clk rising edges after cs_n fall whose samples are discarded (mux settle/null bit), 0..3
NUM_BITS, 8, data bits per conversion, MSB first
GAP_CYCLES, 50, clk cycles cs_n held high between conversions (min 1)
IDX_W, 12, width of sample_index

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; while high, conversions run back-to-back
data_in  in  6  serial data [0]=A V, [1]=B V, [2]=C V, [3]=A I, [4]=B I, [5]=C I
adc_clk  out  1  ADC serial clock
cs_n  out  1  ADC chip select, active low
phase_a_v, phase_b_v, phase_c_v  out  NUM_BITS each  last captured voltage words
phase_a_i, phase_b_i, phase_c_i  out  NUM_BITS each  last captured current words
data_valid  out  1  one-cycle pulse: all six words updated this cycle
sample_index  out  IDX_W  index of the sample presented with data_valid
busy  out  1  high while cs_n is low

Behaviour:
- Reset, or clk edge with reset=1:
  - cs_n=1, adc_clk=0, all data words=0, data_valid=0, sample_index=0, busy=0.
  - State IDLE; divider, bit counter and shift registers cleared.
  - Applies mid-conversion too: conversion abandoned, no data_valid.
- States: IDLE, CONV, GAP.
- IDLE: cs_n=1, adc_clk=0.
  - If enable=1, next cycle enters CONV with cs_n=0, busy=1, divider=0. That cycle is t=0.
- CONV: N = LEAD_BITS+NUM_BITS.
  - adc_clk rises at t=(2k-1)*CLK_DIV and falls at t=2k*CLK_DIV, for k=1..N.
  - Divider runs continuously; adc_clk duty is exactly 50%.
  - On the clk edge where adc_clk goes 0->1, the current data_in value is shifted into each channel register.
  - Samples for k<=LEAD_BITS are discarded. Sample k=LEAD_BITS+1 is the MSB.
- Completion: at t=2N*CLK_DIV (last adc_clk fall), in the same cycle:
  - cs_n=1, busy=0, data_valid=1.
  - All six output words load together from the shift registers.
  - sample_index presents the current count. Internal count increments afterwards, wrapping 2^IDX_W-1 -> 0.
  - State goes to GAP.
- Defaults: data_valid at t=450.
- Output words hold their value until the next data_valid. They never show partial data.
- GAP: cs_n=1, adc_clk=0 for GAP_CYCLES cycles.
  - Then, if enable=1, go directly to CONV (cs_n falls on the next cycle); else go to IDLE.
  - Default period is 450+50+1=501 clk cycles per sample.
- enable deasserted during CONV: the conversion completes normally, including data_valid. No abort.
- enable toggling inside GAP has no effect until GAP ends.
- data_in is sampled only at adc_clk rising edges. Values at all other times are ignored.

Test Plan:
- Defaults; serial model drives null bit 1, then A V=0xA5, B V=0x3C, C V=0xFF, A I=0x00, B I=0x81, C I=0x7E (changed on adc_clk falls) -> at t=450 data_valid=1 for one cycle, words match exactly, sample_index=0, cs_n rises the same cycle.
- Check adc_clk: 9 rising edges per conversion, high/low 25 cycles each, cs_n low for 450 cycles. Then 50 cycles high with adc_clk=0, next cs_n fall at t=501 with enable held.
- Set LEAD_BITS=0 and drive 0x5A -> captured 0x5A; with LEAD_BITS=1 and the same stream, captured word shifts accordingly.
- Deassert enable at t=200 -> data_valid still at t=450, then IDLE; cs_n stays 1.
- Assert reset at t=300 -> next cycle cs_n=1, adc_clk=0, words=0, no data_valid. Re-enable: first sample index=0.
- IDX_W=3, run 9 conversions -> sample_index sequence 0..7,0; words correct each time. CLK_DIV=2 -> adc_clk period 4 cycles, capture still correct.
